// File: rtl/cci_mpf_shim_pwrite_pkg.sv
// Shared types for the partial-write (pwrite) shim: slot lifecycle states and
// the issue-queue record carried from the write pipeline to the read channel.
package cci_mpf_shim_pwrite_pkg;

  localparam int PWRITE_MASK_W = 64;
  localparam int PWRITE_IDX_W  = 7;
  localparam int PWRITE_ADDR_W = 42;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MASKED  = 2'd1,
    QUEUED  = 2'd2,
    READING = 2'd3
  } t_pwrite_slot_state;

  typedef struct packed {
    logic [PWRITE_IDX_W-1:0]  idx;
    logic [PWRITE_ADDR_W-1:0] addr;
  } t_pwrite_issue;

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small show-ahead FIFO held in LUTRAM: the head entry is visible on first_o
// whenever not_empty_o is high, so a pop adds no latency.
module cci_mpf_prim_fifo_lutram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 49
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             enq_en_i,
  input  logic [WIDTH-1:0] enq_data_i,
  output logic             not_full_o,
  output logic             not_empty_o,
  output logic [WIDTH-1:0] first_o,
  input  logic             deq_en_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_enq, do_deq;

  assign not_full_o  = (cnt_q != (PTR_W+1)'(DEPTH));
  assign not_empty_o = (cnt_q != '0);
  assign first_o     = mem[rd_ptr_q];
  assign do_enq      = enq_en_i && not_full_o;
  assign do_deq      = deq_en_i && not_empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_enq) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_deq) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr_q] <= enq_data_i;
    end
  end

endmodule

// File: rtl/cci_mpf_shim_pwrite_rmw_sched.sv
// Read-modify-write scheduler for the partial-write shim: records byte masks,
// queues one line read per partial write, and returns old data plus mask.
module cci_mpf_shim_pwrite_rmw_sched
  import cci_mpf_shim_pwrite_pkg::*;
#(
  parameter int N_WRITE_HEAP_ENTRIES = 128,
  parameter int ISSUE_FIFO_DEPTH     = 8,
  parameter int MAX_RD_OUTSTANDING   = 16,
  parameter int ADDR_W               = 42,
  localparam int IDX_W = $clog2(N_WRITE_HEAP_ENTRIES),
  localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [IDX_W-1:0]         widx,
  input  logic [PWRITE_MASK_W-1:0] wmask,
  input  logic                     issue_valid,
  input  logic [IDX_W-1:0]         issue_idx,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic                     rd_req_valid,
  output logic [IDX_W-1:0]         rd_req_idx,
  output logic [ADDR_W-1:0]        rd_req_addr,
  input  logic                     rd_req_ready,
  input  logic                     rd_rsp_valid,
  input  logic [IDX_W-1:0]         rd_rsp_idx,
  input  logic [511:0]             rd_rsp_data,
  output logic                     upd_en,
  output logic [IDX_W-1:0]         upd_idx,
  output logic [511:0]             upd_data,
  output logic [PWRITE_MASK_W-1:0] upd_mask,
  output logic [CNT_W-1:0]         rd_outstanding,
  output logic [2:0]               err
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high; valid never depends on ready in this block.

  t_pwrite_slot_state slot_state_q [N_WRITE_HEAP_ENTRIES];
  t_pwrite_slot_state slot_state_d [N_WRITE_HEAP_ENTRIES];

  logic [PWRITE_MASK_W-1:0] mask_mem [N_WRITE_HEAP_ENTRIES];

  logic [CNT_W-1:0]         rd_out_q, rd_out_d;
  logic [2:0]               err_q, err_d;
  logic                     upd_en_q;
  logic [IDX_W-1:0]         upd_idx_q;
  logic [511:0]             upd_data_q;
  logic [PWRITE_MASK_W-1:0] upd_mask_q;

  t_pwrite_issue enq_entry, head_entry;
  logic          fifo_not_full, fifo_not_empty;
  logic [$bits(t_pwrite_issue)-1:0] fifo_first;

  logic wen_ok, iss_fire, iss_idle_wen, iss_ok, iss_err;
  logic rsp_ok, rsp_err, credit_ok, rd_fire;
  t_pwrite_slot_state iss_state;

  assign wen_ok       = wen && (slot_state_q[widx] == IDLE);
  assign iss_state    = slot_state_q[issue_idx];
  assign iss_fire     = issue_valid && issue_ready;
  // A write whose mask lands in the same cycle as its issue is still valid.
  assign iss_idle_wen = (iss_state == IDLE) && wen_ok && (widx == issue_idx);
  assign iss_ok       = iss_fire && ((iss_state == MASKED) || iss_idle_wen);
  assign iss_err      = iss_fire && (iss_state == IDLE) && !iss_idle_wen;
  assign rsp_ok       = rd_rsp_valid && (slot_state_q[rd_rsp_idx] == READING);
  assign rsp_err      = rd_rsp_valid && !rsp_ok;

  assign enq_entry.idx  = issue_idx;
  assign enq_entry.addr = issue_addr;
  assign head_entry     = t_pwrite_issue'(fifo_first);

  cci_mpf_prim_fifo_lutram #(
    .DEPTH (ISSUE_FIFO_DEPTH),
    .WIDTH ($bits(t_pwrite_issue))
  ) u_issue_fifo (
    .clk         (clk),
    .rst_i       (reset),
    .enq_en_i    (iss_ok),
    .enq_data_i  (enq_entry),
    .not_full_o  (fifo_not_full),
    .not_empty_o (fifo_not_empty),
    .first_o     (fifo_first),
    .deq_en_i    (rd_fire)
  );

  assign credit_ok    = (rd_out_q < CNT_W'(MAX_RD_OUTSTANDING));
  assign issue_ready  = fifo_not_full;
  assign rd_req_valid = fifo_not_empty && credit_ok;
  assign rd_req_idx   = head_entry.idx;
  assign rd_req_addr  = head_entry.addr;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  always_comb begin
    slot_state_d = slot_state_q;
    if (rsp_ok) slot_state_d[rd_rsp_idx] = IDLE;
    if (wen_ok) slot_state_d[widx] = MASKED;
    if (iss_ok) slot_state_d[issue_idx] = QUEUED;
    if (rd_fire) slot_state_d[head_entry.idx] = READING;

    case ({rd_fire, rsp_ok})
      2'b10:   rd_out_d = rd_out_q + 1'b1;
      2'b01:   rd_out_d = rd_out_q - 1'b1;
      default: rd_out_d = rd_out_q;
    endcase

    err_d = err_q | {rsp_err, iss_err, wen && !wen_ok};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_WRITE_HEAP_ENTRIES; i++) begin
        slot_state_q[i] <= IDLE;
      end
      rd_out_q   <= '0;
      err_q      <= '0;
      upd_en_q   <= 1'b0;
      upd_idx_q  <= '0;
      upd_data_q <= '0;
      upd_mask_q <= '0;
    end else begin
      slot_state_q <= slot_state_d;
      rd_out_q     <= rd_out_d;
      err_q        <= err_d;
      upd_en_q     <= rsp_ok;
      if (rsp_ok) begin
        upd_idx_q  <= rd_rsp_idx;
        upd_data_q <= rd_rsp_data;
        upd_mask_q <= mask_mem[rd_rsp_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen_ok) begin
      mask_mem[widx] <= wmask;
    end
  end

  assign upd_en         = upd_en_q;
  assign upd_idx        = upd_idx_q;
  assign upd_data       = upd_data_q;
  assign upd_mask       = upd_mask_q;
  assign rd_outstanding = rd_out_q;
  assign err            = err_q;

endmodule
